// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Width codes match the memory's mem_width encoding.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_t;

   typedef enum logic {
      GntIf,
      GntDm
   } grant_t;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and backing-memory handshake signals.
// Suffixes are relative to the arbiter; slave is the arbiter side.
interface mem_port_arbiter_if;

   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_ready_o;
   logic [31:0] if_rdata_o;

   logic        dm_req_i;
   logic        dm_we_i;
   logic [1:0]  dm_width_i;
   logic [31:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_ready_o;
   logic [31:0] dm_rdata_o;

   logic        err_o;
   logic        busy_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [1:0]  mem_width_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_ready_o, if_rdata_o,
      input  dm_req_i, dm_we_i, dm_width_i, dm_addr_i, dm_wdata_i,
      output dm_ready_o, dm_rdata_o,
      output err_o, busy_o,
      output mem_req_o, mem_we_o, mem_width_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_ready_o, if_rdata_o,
      output dm_req_i, dm_we_i, dm_width_i, dm_addr_i, dm_wdata_i,
      input  dm_ready_o, dm_rdata_o,
      input  err_o, busy_o,
      input  mem_req_o, mem_we_o, mem_width_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );

endinterface

// File: rtl/arb_streak_select.sv
// Grant decision with a bounded data-priority streak so a pending fetch
// is served after at most MAX_STREAK back-to-back data grants.
module arb_streak_select
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   if_req,
   input  logic   dm_req,
   input  logic   grant_strobe,
   output grant_t grantee
);

   localparam int unsigned SW = $clog2(MAX_STREAK + 1);

   logic [SW-1:0] streak_q;
   logic          at_max;

   assign at_max = (streak_q == SW'(MAX_STREAK));

   always_comb begin
      grantee = GntDm;
      if (if_req && (!dm_req || at_max)) begin
         grantee = GntIf;
      end
   end

   // Only data grants that actually hold off a waiting fetch extend the streak.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         streak_q <= '0;
      end else if (grant_strobe) begin
         if (grantee == GntDm && if_req) begin
            if (!at_max) begin
               streak_q <= streak_q + 1'b1;
            end
         end else begin
            streak_q <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data accesses onto one variable-latency
// memory port, with a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic               clk_i,
   input logic               rst_i,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state_q;
   grant_t        gnt_q;
   grant_t        grantee;
   logic [TW-1:0] tmo_q;
   logic          we_q;
   logic [1:0]    width_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          mem_req_q;
   logic          busy_q;
   logic          if_ready_q;
   logic          dm_ready_q;
   logic          err_q;
   logic [31:0]   if_rdata_q;
   logic [31:0]   dm_rdata_q;

   logic          any_req;
   logic          grant_strobe;
   logic          tmo_hit;
   logic [31:0]   resp_data;

   assign any_req      = bus.if_req_i | bus.dm_req_i;
   assign grant_strobe = (state_q == StIdle) && any_req;
   assign tmo_hit      = (tmo_q == TW'(TIMEOUT - 1));
   // Stores return zero; an abort also returns zero.
   assign resp_data    = (we_q || !bus.mem_ack_i) ? 32'h0 : bus.mem_rdata_i;

   arb_streak_select #(
      .MAX_STREAK(MAX_STREAK)
   ) u_streak (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req      (bus.if_req_i),
      .dm_req      (bus.dm_req_i),
      .grant_strobe(grant_strobe),
      .grantee     (grantee)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         gnt_q      <= GntIf;
         tmo_q      <= '0;
         we_q       <= 1'b0;
         width_q    <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         if_ready_q <= 1'b0;
         dm_ready_q <= 1'b0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (any_req) begin
                  gnt_q     <= grantee;
                  tmo_q     <= '0;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= StWait;
                  if (grantee == GntDm) begin
                     we_q    <= bus.dm_we_i;
                     width_q <= bus.dm_width_i;
                     addr_q  <= bus.dm_addr_i;
                     wdata_q <= bus.dm_wdata_i;
                  end else begin
                     we_q    <= 1'b0;
                     width_q <= W_WORD;
                     addr_q  <= bus.if_addr_i;
                     wdata_q <= '0;
                  end
               end
            end
            StWait: begin
               // An ack in the last watchdog cycle still completes cleanly.
               if (bus.mem_ack_i || tmo_hit) begin
                  mem_req_q <= 1'b0;
                  err_q     <= !bus.mem_ack_i;
                  state_q   <= StResp;
                  if (gnt_q == GntIf) begin
                     if_ready_q <= 1'b1;
                     if_rdata_q <= resp_data;
                  end else begin
                     dm_ready_q <= 1'b1;
                     dm_rdata_q <= resp_data;
                  end
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            StResp: begin
               if_ready_q <= 1'b0;
               dm_ready_q <= 1'b0;
               err_q      <= 1'b0;
               if_rdata_q <= '0;
               dm_rdata_q <= '0;
               busy_q     <= 1'b0;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = we_q;
   assign bus.mem_width_o = width_q;
   assign bus.mem_addr_o  = addr_q;
   assign bus.mem_wdata_o = wdata_q;
   assign bus.if_ready_o  = if_ready_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.dm_ready_o  = dm_ready_q;
   assign bus.dm_rdata_o  = dm_rdata_q;
   assign bus.err_o       = err_q;
   assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, fairness, watchdog and reset.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned errors = 0;
   int unsigned checks = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .MAX_STREAK(4),
      .TIMEOUT   (64)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_mem_req"}, 32'(bus.mem_req_o), 32'd0);
      chk({tag, "_if_ready"}, 32'(bus.if_ready_o), 32'd0);
      chk({tag, "_dm_ready"}, 32'(bus.dm_ready_o), 32'd0);
      chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
   endtask

   task automatic clear_inputs();
      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = '0;
      bus.dm_req_i    = 1'b0;
      bus.dm_we_i     = 1'b0;
      bus.dm_width_i  = 2'b00;
      bus.dm_addr_i   = '0;
      bus.dm_wdata_i  = '0;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = '0;
   endtask

   bit exp_if [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      clear_inputs();
      tick();
      tick();
      chk_quiet("reset");
      chk("reset_if_rdata", bus.if_rdata_o, 32'h0);
      chk("reset_dm_rdata", bus.dm_rdata_o, 32'h0);
      chk("reset_mem_addr", bus.mem_addr_o, 32'h0);
      rst = 1'b0;

      // Fetch only, ack in the third WAIT cycle.
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h100;
      tick();
      chk("f1_mem_req", 32'(bus.mem_req_o), 32'd1);
      chk("f1_mem_addr", bus.mem_addr_o, 32'h100);
      chk("f1_mem_we", 32'(bus.mem_we_o), 32'd0);
      chk("f1_mem_width", 32'(bus.mem_width_o), 32'(W_WORD));
      chk("f1_busy", 32'(bus.busy_o), 32'd1);
      tick();
      chk("f1_hold_req", 32'(bus.mem_req_o), 32'd1);
      chk("f1_no_early_ready", 32'(bus.if_ready_o), 32'd0);
      tick();
      chk("f1_no_early_ready2", 32'(bus.if_ready_o), 32'd0);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hDEADBEEF;
      tick();
      chk("f1_if_ready", 32'(bus.if_ready_o), 32'd1);
      chk("f1_if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
      chk("f1_dm_ready", 32'(bus.dm_ready_o), 32'd0);
      chk("f1_err", 32'(bus.err_o), 32'd0);
      chk("f1_mem_req_drop", 32'(bus.mem_req_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      bus.if_req_i  = 1'b0;
      tick();
      chk_quiet("f1_idle");

      // Simultaneous fetch and store: data first, store returns zero.
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h200;
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = 1'b1;
      bus.dm_width_i = W_WORD;
      bus.dm_addr_i  = 32'h80;
      bus.dm_wdata_i = 32'h12345678;
      tick();
      chk("s2_mem_addr", bus.mem_addr_o, 32'h80);
      chk("s2_mem_we", 32'(bus.mem_we_o), 32'd1);
      chk("s2_mem_wdata", bus.mem_wdata_o, 32'h12345678);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hAAAAAAAA;
      tick();
      chk("s2_dm_ready", 32'(bus.dm_ready_o), 32'd1);
      chk("s2_dm_rdata", bus.dm_rdata_o, 32'h0);
      chk("s2_if_ready", 32'(bus.if_ready_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      bus.dm_req_i  = 1'b0;
      tick();
      tick();
      chk("s2_f_mem_addr", bus.mem_addr_o, 32'h200);
      chk("s2_f_mem_we", 32'(bus.mem_we_o), 32'd0);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'hCAFEF00D;
      tick();
      chk("s2_f_if_ready", 32'(bus.if_ready_o), 32'd1);
      chk("s2_f_if_rdata", bus.if_rdata_o, 32'hCAFEF00D);
      chk("s2_f_dm_ready", 32'(bus.dm_ready_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      bus.if_req_i  = 1'b0;
      tick();

      // Fairness: both held, expect DM x4 then IF then DM.
      bus.if_req_i   = 1'b1;
      bus.if_addr_i  = 32'h300;
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = 1'b0;
      bus.dm_width_i = W_BYTE;
      bus.dm_addr_i  = 32'h40;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("fair%0d_addr", i), bus.mem_addr_o, exp_if[i] ? 32'h300 : 32'h40);
         chk($sformatf("fair%0d_width", i), 32'(bus.mem_width_o),
             exp_if[i] ? 32'(W_WORD) : 32'(W_BYTE));
         bus.mem_ack_i   = 1'b1;
         bus.mem_rdata_i = 32'hF000 + 32'(i);
         tick();
         chk($sformatf("fair%0d_if_ready", i), 32'(bus.if_ready_o), 32'(exp_if[i]));
         chk($sformatf("fair%0d_dm_ready", i), 32'(bus.dm_ready_o), 32'(!exp_if[i]));
         chk($sformatf("fair%0d_rdata", i), exp_if[i] ? bus.if_rdata_o : bus.dm_rdata_o,
             32'hF000 + 32'(i));
         bus.mem_ack_i = 1'b0;
         if (i == 5) begin
            bus.if_req_i = 1'b0;
            bus.dm_req_i = 1'b0;
         end
         tick();
      end

      // Watchdog: no ack for 64 WAIT cycles.
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = 1'b0;
      bus.dm_width_i = W_HALF;
      bus.dm_addr_i  = 32'h44;
      tick();
      chk("t4_mem_req", 32'(bus.mem_req_o), 32'd1);
      chk("t4_mem_width", 32'(bus.mem_width_o), 32'(W_HALF));
      for (int i = 0; i < 63; i++) tick();
      chk("t4_last_wait_req", 32'(bus.mem_req_o), 32'd1);
      chk("t4_last_wait_ready", 32'(bus.dm_ready_o), 32'd0);
      tick();
      chk("t4_dm_ready", 32'(bus.dm_ready_o), 32'd1);
      chk("t4_err", 32'(bus.err_o), 32'd1);
      chk("t4_dm_rdata", bus.dm_rdata_o, 32'h0);
      chk("t4_mem_req_drop", 32'(bus.mem_req_o), 32'd0);
      bus.dm_req_i    = 1'b0;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h99;
      tick();
      tick();
      chk_quiet("t4_late_ack");
      bus.mem_ack_i  = 1'b0;
      bus.dm_req_i   = 1'b1;
      bus.dm_width_i = W_WORD;
      bus.dm_addr_i  = 32'h48;
      tick();
      chk("t4_next_addr", bus.mem_addr_o, 32'h48);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h11223344;
      tick();
      chk("t4_next_ready", 32'(bus.dm_ready_o), 32'd1);
      chk("t4_next_rdata", bus.dm_rdata_o, 32'h11223344);
      chk("t4_next_err", 32'(bus.err_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      bus.dm_req_i  = 1'b0;
      tick();

      // Reset in the third WAIT cycle, then a stray ack.
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h500;
      tick();
      chk("r5_mem_req", 32'(bus.mem_req_o), 32'd1);
      tick();
      tick();
      rst          = 1'b1;
      bus.if_req_i = 1'b0;
      tick();
      chk_quiet("r5_after_reset");
      rst             = 1'b0;
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h77;
      tick();
      chk_quiet("r5_stray_ack");
      chk("r5_if_rdata", bus.if_rdata_o, 32'h0);
      chk("r5_mem_addr", bus.mem_addr_o, 32'h0);
      chk("r5_mem_width", 32'(bus.mem_width_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      tick();

      // Ack in the final watchdog cycle wins over the timeout.
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = 1'b0;
      bus.dm_width_i = W_WORD;
      bus.dm_addr_i  = 32'h60;
      tick();
      for (int i = 0; i < 63; i++) tick();
      chk("a6_still_wait", 32'(bus.mem_req_o), 32'd1);
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = 32'h55;
      tick();
      chk("a6_dm_ready", 32'(bus.dm_ready_o), 32'd1);
      chk("a6_dm_rdata", bus.dm_rdata_o, 32'h55);
      chk("a6_err", 32'(bus.err_o), 32'd0);
      bus.mem_ack_i = 1'b0;
      bus.dm_req_i  = 1'b0;
      tick();
      tick();
      chk_quiet("a6_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the instruction-fetch port (read-only) and the data-memory port (read/write, byte/half/word).
- Sits between the pipeline's fetch and data-access stages and the unified memory.
- Serialises requests through a request/ready handshake.
- Data accesses have priority, but a bounded-streak rule prevents fetch starvation.
- A watchdog terminates accesses the memory never acknowledges.

Parameters:
- MAX_STREAK, 4: maximum consecutive data grants while a fetch is pending.
- TIMEOUT, 64: WAIT cycles without mem_ack_i before the access is aborted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held with if_addr_i until if_ready_o
- if_addr_i  in  32  fetch address
- if_ready_o  out  1  one-cycle completion pulse for fetch
- if_rdata_o  out  32  fetched word; valid while if_ready_o=1
- dm_req_i  in  1  data request; held with its fields until dm_ready_o
- dm_we_i  in  1  1 = store
- dm_width_i  in  2  00 byte, 01 half, 10 word
- dm_addr_i  in  32  data address
- dm_wdata_i  in  32  store data
- dm_ready_o  out  1  one-cycle completion pulse for data
- dm_rdata_o  out  32  load data; valid while dm_ready_o=1
- err_o  out  1  pulses together with a ready pulse when the access timed out
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_width_o  out  2  access width
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_ack_i  in  1  memory done; mem_rdata_i valid in the same cycle
- mem_rdata_i  in  32  memory read data
- busy_o  out  1  high in WAIT and RESP

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE; all outputs 0; streak counter 0; timeout counter 0; latched request fields 0.
- Reset mid-access: forces IDLE on the next edge, drops mem_req_o, and suppresses the ready pulse. A late mem_ack_i is ignored.

States:
- IDLE: if no request is pending, stay.
  - Otherwise select the grantee, latch its fields (fetch: we=0, width=10), clear the timeout counter, go to WAIT.
- WAIT: mem_req_o=1 and mem_* are driven from the latched fields, stable throughout.
  - On mem_ack_i=1: register mem_rdata_i into the grantee's rdata output, go to RESP.
  - Otherwise, if the timeout counter equals TIMEOUT-1: rdata=0, set error flag, go to RESP.
  - Otherwise increment the timeout counter.
- RESP: the grantee's ready_o=1 for exactly one cycle; err_o=1 if flagged. Go to IDLE. mem_req_o=0.

Grant selection (IDLE):
- Only one requester pending: grant it.
- Both pending: grant data unless streak==MAX_STREAK, in which case grant fetch.
- Streak counter:
  - Increments on a data grant while if_req_i=1.
  - Clears on any fetch grant, or on a data grant with if_req_i=0.
  - Saturates at MAX_STREAK.

Latency and handshake:
- Request at cycle N (IDLE), ack at N+k (k≥1), ready at N+k+1. Minimum 3 cycles per access; no overlap.
- A request still high in the IDLE cycle after its ready pulse is a new request.
- Stores: rdata output is 0 with the ready pulse; mem_rdata_i is ignored.
- ready_o/err_o never assert for a non-grantee. if_ready_o and dm_ready_o are never high together.
- mem_ack_i outside WAIT is ignored.
- Simultaneous ack and timeout in the same cycle: the ack wins, with no error.

Decomposition:
- Shared package (mem_arb_pkg):
  - state enum IDLE/WAIT/RESP
  - width constants W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10
  - grantee encoding GNT_IF/GNT_DM
- Sub-module arb_streak_select: streak counter plus grant decision. Inputs: clk_i, rst_i, if_req, dm_req, grant_strobe. Output: grantee.
- The FSM, timeout counter and output registers stay in the top.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x100, ack 2 cycles after mem_req_o with rdata 0xDEADBEEF → mem_addr_o=0x100, mem_we_o=0, mem_width_o=10; if_ready_o pulses once with if_rdata_o=0xDEADBEEF, exactly 4 cycles after the request.
- Simultaneous requests, both held: fetch 0x200; store to 0x80, word, 0x12345678 → data granted first with mem_we_o=1 and mem_wdata_o=0x12345678; dm_ready_o with dm_rdata_o=0; then fetch served.
- Fairness, MAX_STREAK=4: dm_req_i re-asserted continuously alongside if_req_i → grants DM,DM,DM,DM,IF,DM…; if_ready_o occurs after the 4th dm_ready_o.
- Timeout, TIMEOUT=64, mem_ack_i held 0 → after 64 WAIT cycles, dm_ready_o=1, err_o=1, dm_rdata_o=0; late ack ignored; next access completes normally.
- Reset at WAIT cycle 3 → mem_req_o=0 the next cycle; no ready pulse; ack one cycle after reset produces no response; all outputs 0.
- Ack exactly in the final timeout cycle, rdata 0x55 → ready with rdata 0x55, err_o=0.
